// File: rtl/rop_types.sv
// Shared ROP type definitions: render-target state, DCR layout constants and commit FSM states.
package rop_types;

    localparam int unsigned ROP_ADDR_BITS     = 32;
    localparam int unsigned ROP_PITCH_BITS    = 16;
    localparam int unsigned ROP_DCR_RT_STRIDE = 3;

    typedef struct packed {
        logic [ROP_ADDR_BITS-1:0]  cbuf_addr;
        logic [ROP_PITCH_BITS-1:0] cbuf_pitch;
        logic [3:0]                cbuf_writemask;
    } rop_rt_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } rop_commit_state_e;

endpackage

// File: rtl/rop_inflight_counter.sv
// Outstanding-fragment counter: +1 on inc, -1 on dec, saturating at 0 and MAX.
module rop_inflight_counter #(
    parameter int unsigned MAX = 63,
    localparam int unsigned W  = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         zero_next
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    logic         inc_eff;
    logic         dec_eff;
    logic [W-1:0] count_d;

    assign full    = (count == CNT_MAX);
    assign inc_eff = inc && !full;
    // A retire with nothing in flight is dropped rather than wrapping.
    assign dec_eff = dec && (count != '0);

    always_comb begin
        count_d = count;
        if (inc_eff && !dec_eff) begin
            count_d = count + 1'b1;
        end else if (dec_eff && !inc_eff) begin
            count_d = count - 1'b1;
        end
    end

    assign zero_next = (count_d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) dec |-> count != '0)
        else $warning("rop_inflight_counter: retire with no fragment in flight");

endmodule

// File: rtl/rop_dcr_bank.sv
// Double-buffered ROP render-state bank: DCR writes land in shadow registers and are copied
// to the active set once all in-flight fragments retire; per-target state follows rt_idx.
module rop_dcr_bank
    import rop_types::*;
#(
    parameter int unsigned NUM_RT       = 4,
    parameter int unsigned SHARED_REGS  = 16,
    parameter int unsigned INFLIGHT_MAX = 63,
    localparam int unsigned RT_BITS     = (NUM_RT > 1) ? $clog2(NUM_RT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dcr_wr_valid,
    input  logic [7:0]                dcr_wr_addr,
    input  logic [31:0]               dcr_wr_data,
    input  logic                      commit_req,
    output logic                      commit_done,
    input  logic                      frag_valid,
    output logic                      frag_ready,
    input  logic [RT_BITS-1:0]        frag_rt_idx,
    input  logic                      frag_retire,
    output logic                      rt_sel_valid,
    output logic [ROP_ADDR_BITS-1:0]  rt_cbuf_addr,
    output logic [ROP_PITCH_BITS-1:0] rt_cbuf_pitch,
    output logic [3:0]                rt_cbuf_writemask,
    output logic [SHARED_REGS*32-1:0] active_shared,
    output logic                      busy
);

    localparam int unsigned SH_BASE = ROP_DCR_RT_STRIDE * NUM_RT;
    localparam int unsigned CNT_W   = $clog2(INFLIGHT_MAX + 1);

    rop_commit_state_e         state;
    rop_rt_state_t             shadow_rt_q [NUM_RT];
    rop_rt_state_t             shadow_rt_d [NUM_RT];
    rop_rt_state_t             active_rt   [NUM_RT];
    logic [SHARED_REGS*32-1:0] shadow_sh_q;
    logic [SHARED_REGS*32-1:0] shadow_sh_d;
    logic [CNT_W-1:0]          count;
    logic                      cnt_full;
    logic                      cnt_zero_next;
    logic                      accept;
    logic [RT_BITS-1:0]        rt_sel;

    assign frag_ready = (state == IDLE) && !cnt_full;
    assign accept     = frag_valid && frag_ready;
    assign busy       = (state != IDLE);
    assign rt_sel     = (int'(frag_rt_idx) < NUM_RT) ? frag_rt_idx : '0;

    rop_inflight_counter #(
        .MAX (INFLIGHT_MAX)
    ) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .inc       (accept),
        .dec       (frag_retire),
        .count     (count),
        .full      (cnt_full),
        .zero_next (cnt_zero_next)
    );

    always_comb begin
        shadow_rt_d = shadow_rt_q;
        shadow_sh_d = shadow_sh_q;
        if (dcr_wr_valid) begin
            for (int r = 0; r < NUM_RT; r++) begin
                if (int'(dcr_wr_addr) == ROP_DCR_RT_STRIDE * r) begin
                    shadow_rt_d[r].cbuf_addr = dcr_wr_data[ROP_ADDR_BITS-1:0];
                end
                if (int'(dcr_wr_addr) == ROP_DCR_RT_STRIDE * r + 1) begin
                    shadow_rt_d[r].cbuf_pitch = dcr_wr_data[ROP_PITCH_BITS-1:0];
                end
                if (int'(dcr_wr_addr) == ROP_DCR_RT_STRIDE * r + 2) begin
                    shadow_rt_d[r].cbuf_writemask = dcr_wr_data[3:0];
                end
            end
            for (int k = 0; k < SHARED_REGS; k++) begin
                if (int'(dcr_wr_addr) == SH_BASE + k) begin
                    shadow_sh_d[k*32 +: 32] = dcr_wr_data;
                end
            end
        end
    end

    // Active copy takes the next-shadow value so a write in the COMMIT cycle is included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_RT; r++) begin
                shadow_rt_q[r] <= '0;
                active_rt[r]   <= '0;
            end
            shadow_sh_q   <= '0;
            active_shared <= '0;
        end else begin
            shadow_rt_q <= shadow_rt_d;
            shadow_sh_q <= shadow_sh_d;
            if (state == COMMIT) begin
                active_rt     <= shadow_rt_d;
                active_shared <= shadow_sh_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            commit_done <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_req) begin
                        state <= (count == '0 && !accept) ? COMMIT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_zero_next) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state       <= IDLE;
                    commit_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rt_sel_valid      <= 1'b0;
            rt_cbuf_addr      <= '0;
            rt_cbuf_pitch     <= '0;
            rt_cbuf_writemask <= '0;
        end else begin
            rt_sel_valid <= accept;
            if (accept) begin
                rt_cbuf_addr      <= active_rt[rt_sel].cbuf_addr;
                rt_cbuf_pitch     <= active_rt[rt_sel].cbuf_pitch;
                rt_cbuf_writemask <= active_rt[rt_sel].cbuf_writemask;
            end
        end
    end

    a_rt_idx_range: assert property (@(posedge clk) disable iff (!reset)
        accept |-> int'(frag_rt_idx) < NUM_RT)
        else $warning("rop_dcr_bank: frag_rt_idx %0d out of range, using target 0", frag_rt_idx);

endmodule

// File: tb/tb_rop_dcr_bank.sv
// Scoreboard bench for rop_dcr_bank: stimulus queues expected selects and commits,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_rop_dcr_bank;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         dcr_wr_valid = 1'b0;
    logic [7:0]   dcr_wr_addr = '0;
    logic [31:0]  dcr_wr_data = '0;
    logic         commit_req = 1'b0;
    logic         commit_done;
    logic         frag_valid = 1'b0;
    logic         frag_ready;
    logic [1:0]   frag_rt_idx = '0;
    logic         frag_retire = 1'b0;
    logic         rt_sel_valid;
    logic [31:0]  rt_cbuf_addr;
    logic [15:0]  rt_cbuf_pitch;
    logic [3:0]   rt_cbuf_writemask;
    logic [511:0] active_shared;
    logic         busy;

    // Second instance with a non-power-of-two target count so an out-of-range index exists.
    logic         d2_wr_valid = 1'b0;
    logic [7:0]   d2_wr_addr = '0;
    logic [31:0]  d2_wr_data = '0;
    logic         d2_commit_req = 1'b0;
    logic         d2_commit_done;
    logic         d2_frag_valid = 1'b0;
    logic         d2_frag_ready;
    logic [2:0]   d2_frag_rt_idx = '0;
    logic         d2_sel_valid;
    logic [31:0]  d2_addr;
    logic [15:0]  d2_pitch;
    logic [3:0]   d2_mask;
    logic [511:0] d2_shared;
    logic         d2_busy;

    rop_dcr_bank #(.NUM_RT(4), .SHARED_REGS(16), .INFLIGHT_MAX(63)) dut (
        .clk               (clk),
        .reset             (reset),
        .dcr_wr_valid      (dcr_wr_valid),
        .dcr_wr_addr       (dcr_wr_addr),
        .dcr_wr_data       (dcr_wr_data),
        .commit_req        (commit_req),
        .commit_done       (commit_done),
        .frag_valid        (frag_valid),
        .frag_ready        (frag_ready),
        .frag_rt_idx       (frag_rt_idx),
        .frag_retire       (frag_retire),
        .rt_sel_valid      (rt_sel_valid),
        .rt_cbuf_addr      (rt_cbuf_addr),
        .rt_cbuf_pitch     (rt_cbuf_pitch),
        .rt_cbuf_writemask (rt_cbuf_writemask),
        .active_shared     (active_shared),
        .busy              (busy)
    );

    rop_dcr_bank #(.NUM_RT(5), .SHARED_REGS(16), .INFLIGHT_MAX(63)) dut5 (
        .clk               (clk),
        .reset             (reset),
        .dcr_wr_valid      (d2_wr_valid),
        .dcr_wr_addr       (d2_wr_addr),
        .dcr_wr_data       (d2_wr_data),
        .commit_req        (d2_commit_req),
        .commit_done       (d2_commit_done),
        .frag_valid        (d2_frag_valid),
        .frag_ready        (d2_frag_ready),
        .frag_rt_idx       (d2_frag_rt_idx),
        .frag_retire       (1'b0),
        .rt_sel_valid      (d2_sel_valid),
        .rt_cbuf_addr      (d2_addr),
        .rt_cbuf_pitch     (d2_pitch),
        .rt_cbuf_writemask (d2_mask),
        .active_shared     (d2_shared),
        .busy              (d2_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] pitch;
        logic [3:0]  mask;
    } sel_t;

    typedef struct {
        int          cyc;
        logic [31:0] w2;
    } done_t;

    sel_t  exp_sel[$];
    done_t exp_done[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rt_sel_valid) begin
                if (exp_sel.size() == 0) begin
                    chk("unexpected_rt_sel_valid", 1, 0);
                end else begin
                    sel_t e;
                    e = exp_sel.pop_front();
                    chk("rt_cbuf_addr", rt_cbuf_addr, e.addr);
                    chk("rt_cbuf_pitch", rt_cbuf_pitch, e.pitch);
                    chk("rt_cbuf_writemask", rt_cbuf_writemask, e.mask);
                end
            end
            if (commit_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_commit_done", 1, 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("commit_done_cycle", cyc, d.cyc);
                    chk("active_shared_w2", active_shared[95:64], d.w2);
                    chk("frag_ready_at_done", frag_ready, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        dcr_wr_valid = 1'b1;
        dcr_wr_addr  = a;
        dcr_wr_data  = d;
        tick();
        dcr_wr_valid = 1'b0;
    endtask

    task automatic retire(input int n);
        frag_retire = 1'b1;
        repeat (n) tick();
        frag_retire = 1'b0;
    endtask

    task automatic issue(input logic [1:0] idx, input sel_t e);
        frag_valid  = 1'b1;
        frag_rt_idx = idx;
        exp_sel.push_back(e);
        tick();
        frag_valid = 1'b0;
        retire(1);
    endtask

    task automatic commit_now(input logic [31:0] w2);
        commit_req = 1'b1;
        exp_done.push_back('{cyc: cyc + 2, w2: w2});
        tick();
        commit_req = 1'b0;
    endtask

    localparam logic [31:0] RT1_ADDR = 32'h0100_0000;
    localparam logic [31:0] RT2_ADDR = 32'hAAAA_5555;

    initial begin
        sel_t         zero_s;
        sel_t         rt1_s;
        sel_t         rt2_s;
        logic [511:0] exp_vec;
        zero_s = '{addr: 32'h0, pitch: 16'h0, mask: 4'h0};
        rt1_s  = '{addr: RT1_ADDR, pitch: 16'h0040, mask: 4'hF};
        rt2_s  = '{addr: RT2_ADDR, pitch: 16'h0, mask: 4'h0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_frag_ready", frag_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_commit_done", commit_done, 0);
        chk("reset_rt_sel_valid", rt_sel_valid, 0);
        chk("reset_rt_fields", {rt_cbuf_addr, rt_cbuf_pitch, rt_cbuf_writemask}, 0);
        chk("reset_active_shared_zero", {63'd0, |active_shared}, 0);

        // Shadow writes are invisible until commit.
        wr(8'd3, RT1_ADDR);
        wr(8'd4, 32'h1234_0040);
        wr(8'd5, 32'h0000_00FF);
        wr(8'd6, RT2_ADDR);
        issue(2'd1, zero_s);
        commit_now(32'h0);
        repeat (3) tick();
        issue(2'd1, rt1_s);
        issue(2'd2, rt2_s);

        // Drain: commit waits for five outstanding fragments.
        frag_valid  = 1'b1;
        frag_rt_idx = 2'd2;
        for (int i = 0; i < 5; i++) begin
            exp_sel.push_back(rt2_s);
            tick();
        end
        frag_valid = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("drain_frag_ready", frag_ready, 0);
        chk("drain_busy", busy, 1);
        frag_valid  = 1'b1;
        frag_rt_idx = 2'd0;
        repeat (4) tick();
        chk("drain_still_busy", busy, 1);
        frag_valid  = 1'b0;
        frag_retire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_done.push_back('{cyc: cyc + 2, w2: 32'h0});
            tick();
        end
        frag_retire = 1'b0;
        repeat (3) tick();
        chk("post_drain_frag_ready", frag_ready, 1);
        chk("post_drain_busy", busy, 0);

        // Fill to the limit; a same-cycle issue+retire at 62 leaves the count alone.
        frag_valid  = 1'b1;
        frag_rt_idx = 2'd1;
        for (int i = 0; i < 62; i++) begin
            exp_sel.push_back(rt1_s);
            tick();
        end
        frag_retire = 1'b1;
        exp_sel.push_back(rt1_s);
        tick();
        frag_retire = 1'b0;
        chk("count62_frag_ready", frag_ready, 1);
        exp_sel.push_back(rt1_s);
        tick();
        chk("count63_frag_ready", frag_ready, 0);
        tick();
        chk("count63_held_frag_ready", frag_ready, 0);
        frag_valid = 1'b0;
        retire(1);
        chk("retire_from63_frag_ready", frag_ready, 1);
        retire(62);

        // Out-of-range write, then a write in the COMMIT cycle itself.
        wr(8'd28, 32'hFFFF_FFFF);
        wr(8'd255, 32'hFFFF_FFFF);
        commit_req = 1'b1;
        exp_done.push_back('{cyc: cyc + 2, w2: 32'hDEAD_BEEF});
        tick();
        commit_req = 1'b0;
        chk("commit_cycle_busy", busy, 1);
        wr(8'd14, 32'hDEAD_BEEF);
        repeat (2) tick();
        exp_vec          = '0;
        exp_vec[95:64]   = 32'hDEAD_BEEF;
        chk("active_shared_only_w2", {63'd0, active_shared == exp_vec}, 1);
        issue(2'd3, zero_s);
        issue(2'd1, rt1_s);

        // Out-of-range target index on the five-target instance selects target 0.
        d2_wr_valid = 1'b1;
        d2_wr_addr  = 8'd0;
        d2_wr_data  = 32'h0000_CAFE;
        tick();
        d2_wr_addr = 8'd12;
        d2_wr_data = 32'h0000_BEEF;
        tick();
        d2_wr_valid   = 1'b0;
        d2_commit_req = 1'b1;
        tick();
        d2_commit_req = 1'b0;
        repeat (3) tick();
        d2_frag_valid  = 1'b1;
        d2_frag_rt_idx = 3'd7;
        tick();
        chk("rt5_idx7_valid", d2_sel_valid, 1);
        chk("rt5_idx7_addr", d2_addr, 32'h0000_CAFE);
        d2_frag_rt_idx = 3'd4;
        tick();
        d2_frag_valid = 1'b0;
        chk("rt5_idx4_addr", d2_addr, 32'h0000_BEEF);

        // Reset mid-DRAIN drops the pending commit.
        issue(2'd1, rt1_s);
        frag_valid  = 1'b1;
        frag_rt_idx = 2'd0;
        exp_sel.push_back(zero_s);
        tick();
        frag_valid = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("mid_drain_reset_busy", busy, 0);
        chk("mid_drain_reset_frag_ready", frag_ready, 1);
        chk("mid_drain_reset_active_zero", {63'd0, |active_shared}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) tick();
        chk("after_reset_busy", busy, 0);

        chk("sel_queue_drained", exp_sel.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
